// File: rtl/byte_mem_responder_if.sv
// byte_mem_responder_if
//   Byte-wide memory bus between a multicycle controller (master) and the
//   memory responder (slave).
//
//   Handshake: the master holds MemRead or MemWrite high (level) together
//   with Adr/WriteData until it sees MemReady. The responder samples the
//   request only while idle. MemReady is a single-cycle completion strobe.
//   MemData and Err are meaningful in the MemReady cycle. MemData then
//   holds until the next successful read.
//
//   Signals
//     MemRead, MemWrite  master -> slave  request strobes (level)
//     Adr                master -> slave  byte address
//     WriteData          master -> slave  write byte
//     MemData            slave -> master  read data
//     MemReady           slave -> master  one-cycle completion strobe
//     Busy               slave -> master  responder not idle
//     Err                slave -> master  error, pulses with MemReady
//     dbg_state          slave -> master  responder FSM state (observation only)
interface byte_mem_responder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  MemRead;
   logic                  MemWrite;
   logic [ADDR_WIDTH-1:0] Adr;
   logic [7:0]            WriteData;
   logic [7:0]            MemData;
   logic                  MemReady;
   logic                  Busy;
   logic                  Err;
   logic [1:0]            dbg_state;

   modport master (
      output MemRead, MemWrite, Adr, WriteData,
      input  MemData, MemReady, Busy, Err, dbg_state
   );

   modport slave (
      input  MemRead, MemWrite, Adr, WriteData,
      output MemData, MemReady, Busy, Err, dbg_state
   );
endinterface

// File: rtl/byte_mem_responder.sv
// byte_mem_responder
//   Memory-side responder for a byte-wide controller bus. It latches a
//   read or write request while idle, spends WAIT_STATES cycles in WAIT,
//   then performs the access on an internal byte array. The access edge
//   raises MemReady for one cycle.
//
//   Ports
//     ph1    clock, all state changes on the rising edge
//     reset  synchronous, active-low reset
//     bus    byte_mem_responder_if slave modport (request in, data/status out)
//
//   The array contents are not reset. A reset during WAIT or ACCESS drops
//   the pending access, so no write happens and no MemReady is issued.
module byte_mem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                  ph1,
   input  logic                  reset,
   byte_mem_responder_if.slave   bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Counter load value. It is unused when WAIT_STATES is 0, because IDLE
   // then goes straight to ACCESS.
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  start;
   logic                  do_access;

   logic [ADDR_WIDTH-1:0] lat_adr;
   logic [7:0]            lat_wd;
   logic                  lat_rd;
   logic                  lat_wr;

   logic [7:0]            mem_data_q;
   logic                  ready_q;
   logic                  err_q;
   logic                  busy_q;

   logic [7:0]            mem [DEPTH];

   logic                  in_range;
   logic                  conflict;
   logic [IDX_W-1:0]      idx;

   assign in_range  = (32'(lat_adr) < 32'(DEPTH));
   assign conflict  = lat_rd & lat_wr;
   assign idx       = lat_adr[IDX_W-1:0];
   assign do_access = (state_q == S_ACCESS);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.MemRead | bus.MemWrite) begin
               start = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            // Request inputs are ignored here. Only the latched copy matters.
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State register, request latches and registered outputs
   always_ff @(posedge ph1) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         mem_data_q <= 8'h00;
         lat_adr    <= '0;
         lat_wd     <= 8'h00;
         lat_rd     <= 1'b0;
         lat_wr     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Busy follows the state register, so it tracks "not in IDLE".
         busy_q  <= (state_d != S_IDLE);
         ready_q <= do_access;
         err_q   <= do_access & (conflict | ~in_range);
         if (start) begin
            lat_adr <= bus.Adr;
            lat_wd  <= bus.WriteData;
            lat_rd  <= bus.MemRead;
            lat_wr  <= bus.MemWrite;
         end
         if (do_access && lat_rd && !lat_wr) begin
            mem_data_q <= in_range ? mem[idx] : 8'hFF;
         end
      end
   end

   // Array write. It has no reset, so contents survive reset. The reset
   // term blocks a write that is pending when reset arrives.
   always_ff @(posedge ph1) begin
      if (reset && do_access && lat_wr && !lat_rd && in_range) begin
         mem[idx] <= lat_wd;
      end
   end

   assign bus.MemData   = mem_data_q;
   assign bus.MemReady  = ready_q;
   assign bus.Busy      = busy_q;
   assign bus.Err       = err_q;
   assign bus.dbg_state = state_q;

endmodule

// File: doc/byte_mem_responder.md
Name: byte_mem_responder

Overview:
- Memory-side responder for the multicycle controller's byte-wide memory interface.
- Accepts MemRead/MemWrite requests with an address and write byte.
- Performs each access on an internal byte array after a programmable number of wait states.
- Returns read data with a one-cycle MemReady strobe; the controller or a wrapper stalls on it.

Parameters:
ADDR_WIDTH, 8, width of Adr.
DEPTH, 256, number of implemented bytes (must be ≤ 2**ADDR_WIDTH).
WAIT_STATES, 2, cycles spent in WAIT before the access completes (0..15).

Ports:
ph1  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-low (0 = reset), sampled on ph1 rising edge.
MemRead  in  1  read request, level-sensitive.
MemWrite  in  1  write request, level-sensitive.
Adr  in  ADDR_WIDTH  byte address.
WriteData  in  8  write byte.
MemData  out  8  read data; held until the next successful read completes.
MemReady  out  1  one-cycle completion strobe.
Busy  out  1  high whenever the FSM is not in IDLE.
Err  out  1  error flag; pulses together with MemReady.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, MemReady=0, Busy=0, Err=0, MemData=8'h00, wait counter=0.
  - Array contents are not reset and are preserved across reset.
  - Reset mid-operation aborts the access: a pending write is not performed and no MemReady is issued.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - At an edge with MemRead|MemWrite=1, latch Adr, WriteData and op.
  - Go to WAIT with counter=WAIT_STATES-1, or to ACCESS if WAIT_STATES=0.
  - Otherwise stay in IDLE.
- WAIT:
  - Counter decrements each edge; go to ACCESS at the edge where counter=0.
  - Request inputs are ignored; their changes have no effect.
- ACCESS:
  - At the edge leaving ACCESS, perform the latched op.
  - Set MemReady=1 (registered) for exactly one cycle.
  - Return to IDLE.
- Latency:
  - Request sampled at edge 0; access occurs at edge WAIT_STATES+1.
  - MemReady is high for the cycle following edge WAIT_STATES+1.
- Back-to-back: the FSM is in IDLE during the MemReady cycle.
  - A request still high at the edge ending that cycle starts a new access.
  - Continuous requests therefore complete every WAIT_STATES+2 cycles.
- Read: MemData <= mem[latched Adr] on the access edge.
- Write: mem[latched Adr] <= latched WriteData on the access edge; MemData is unchanged.
- Out of range (latched Adr ≥ DEPTH):
  - No array access; read sets MemData=8'hFF.
  - Err=1 with MemReady.
- MemRead and MemWrite both high when sampled: no access, MemData unchanged, Err=1 with MemReady.
- Busy=1 in WAIT and ACCESS, 0 in IDLE; Busy is registered, so it rises the cycle after the sampling edge.
- Err and MemReady are never high outside the ACCESS→IDLE cycle.

Test Plan:
- Reset with requests active: reset=0 for 2 edges while MemWrite=1, Adr=8'h10, WriteData=8'hAA, then release with requests low.
  - Required: MemReady=0, Busy=0, MemData=8'h00 throughout.
  - A later read of 8'h10 does not return 8'hAA unless it was written after reset.
- Write then read, WAIT_STATES=2: write 8'h5C to 8'h03, then read 8'h03.
  - Required: each MemReady rises exactly 3 edges after its request is sampled.
  - Read returns MemData=8'h5C with Err=0.
- Four-byte fetch: preload 8'h00..8'h03 with 8'h08,8'h00,8'h00,8'h03, then hold MemRead=1 while stepping Adr after each MemReady.
  - Required: MemData sequence 8'h08,8'h00,8'h00,8'h03, one strobe every 4 cycles.
- WAIT_STATES=0 build: read a preloaded location.
  - Required: MemReady in the cycle after edge 1; Busy high for exactly 1 cycle.
- Errors, DEPTH=128: read Adr=8'hC0.
  - Required: MemData=8'hFF, Err=1 with MemReady.
  - Then MemRead=MemWrite=1 at Adr=8'h03: Err=1, MemData stays 8'hFF, mem[3] stays unchanged.
- Input changes and reset mid-WAIT:
  - Change Adr/WriteData during WAIT: the latched values are used.
  - Assert reset during WAIT of a write of 8'hEE to 8'h20: no MemReady; a subsequent read of 8'h20 returns its old value.
